// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the SIPO receiver slice.
//   state_t  : receiver frame state (data bits, optional parity bit)
//   DEF_WIDTH: default data bits per frame
//   cnt_w()  : bit-counter width for a given frame width
package sipo_pkg;

   typedef enum logic {S_DATA = 1'b0, S_PAR = 1'b1} state_t;

   localparam int DEF_WIDTH = 4;

   // Counter must be able to hold 0..WIDTH.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_receiver_if.sv
// sipo_receiver_if: serial link inputs plus the word/handshake outputs.
//   master: drives si, sh, sync, rdy, clr; observes q, valid, ovr, perr, busy
//   slave : the receiver side (directions reversed)
interface sipo_receiver_if
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             si;
   logic             sh;
   logic             sync;
   logic             rdy;
   logic             clr;
   logic [WIDTH-1:0] q;
   logic             valid;
   logic             ovr;
   logic             perr;
   logic             busy;

   modport master (output si, sh, sync, rdy, clr,
                   input  q, valid, ovr, perr, busy);

   modport slave  (input  si, sh, sync, rdy, clr,
                   output q, valid, ovr, perr, busy);

endinterface

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: LSB-first shift register plus bit counter.
//   clk, rst : clock, synchronous active-high reset
//   sh, si   : shift enable and serial bit
//   sync     : restart the bit count at this cycle (si is bit 0 if sh=1)
//   done     : this cycle samples the last data bit of a frame
//   word     : register contents after this cycle's shift (complete word when done)
//   active   : bit count is non-zero
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sh,
   input  logic             si,
   input  logic             sync,
   output logic             done,
   output logic [WIDTH-1:0] word,
   output logic             active
);

   localparam int             CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [CNT_W-1:0] cnt;

   // New bits enter at the top, so the first bit ends up in word[0].
   assign word   = {si, sr[WIDTH-1:1]};
   assign done   = sh && !sync && (cnt == LAST);
   assign active = (cnt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else begin
         if (sh) sr <= word;
         if (sync)
            cnt <= sh ? CNT_W'(1) : '0;
         else if (sh)
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sipo_receiver.sv
// sipo_receiver: serial-in/parallel-out receiver with VALID/RDY output and
// sticky overrun flag.
//   clk, rst : clock, synchronous active-high reset (overrides everything)
//   bus      : sipo_receiver_if.slave (si, sh, sync, rdy, clr in;
//              q, valid, ovr, perr, busy out)
// Optional feature macro: PARITY_CHECK_EN -- each frame carries one trailing
// even-parity bit; perr reports a mismatch for the word on q. When undefined
// perr is tied to 0 and the parity state is never entered.
module sipo_receiver
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   sipo_receiver_if.slave  bus
);

   state_t           state_q, state_d;
   logic             core_sh, core_done, core_active;
   logic [WIDTH-1:0] core_word;
   logic             frame_done;
   logic [WIDTH-1:0] new_word;
   logic             new_perr;

   // Shifting pauses while the parity bit is collected, unless a sync
   // restarts the frame with this bit.
   assign core_sh = bus.sh && ((state_q == S_DATA) || bus.sync);

   sipo_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .sh     (core_sh),
      .si     (bus.si),
      .sync   (bus.sync),
      .done   (core_done),
      .word   (core_word),
      .active (core_active)
   );

`ifdef PARITY_CHECK_EN
   // Data word is held here while the parity bit arrives.
   logic [WIDTH-1:0] hold;

   always_ff @(posedge clk) begin
      if (rst)            hold <= '0;
      else if (core_done) hold <= core_word;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_DATA;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      new_word   = core_word;
      new_perr   = 1'b0;
`ifdef PARITY_CHECK_EN
      new_word = hold;
      new_perr = ^{hold, bus.si};
      if (bus.sync) begin
         state_d = S_DATA;
      end else begin
         case (state_q)
            S_DATA: if (core_done) state_d = S_PAR;
            S_PAR: begin
               if (bus.sh) begin
                  frame_done = 1'b1;
                  state_d    = S_DATA;
               end
            end
            default: state_d = S_DATA;
         endcase
      end
`else
      state_d    = S_DATA;
      frame_done = core_done;
`endif
   end

   // Output register and handshake. A completed frame is dropped (and OVR set)
   // only when the previous word is still pending and not being taken now.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.q     <= '0;
         bus.valid <= 1'b0;
         bus.ovr   <= 1'b0;
         bus.perr  <= 1'b0;
      end else begin
         if (bus.clr) bus.ovr <= 1'b0;
         if (frame_done) begin
            if (bus.valid && !bus.rdy) begin
               bus.ovr <= 1'b1;
            end else begin
               bus.q     <= new_word;
               bus.valid <= 1'b1;
               bus.perr  <= new_perr;
            end
         end else if (bus.valid && bus.rdy) begin
            bus.valid <= 1'b0;
            bus.perr  <= 1'b0;
         end
      end
   end

   assign bus.busy = core_active || (state_q == S_PAR);

endmodule

// File: tb/tb_sipo_receiver.sv
// tb_sipo_receiver: directed self-checking bench for sipo_receiver (WIDTH=4).
// Frames are written LSB first; with PARITY_CHECK_EN an even-parity bit is
// appended after each frame's last data bit.
module tb_sipo_receiver;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   sipo_receiver_if #(.WIDTH(W)) bus ();

   sipo_receiver #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are then sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.sh = 1'b1;
      bus.si = b;
      tick();
      bus.sh = 1'b0;
   endtask

   // Last data bit of frame w, with rdy applied on the completing cycle.
   task automatic last_bit(input logic b, input logic [W-1:0] w, input logic rdy_last);
`ifdef PARITY_CHECK_EN
      send_bit(b);
      bus.rdy = rdy_last;
      send_bit(^w);
`else
      bus.rdy = rdy_last;
      send_bit(b);
`endif
      bus.rdy = 1'b0;
   endtask

   task automatic consume();
      bus.rdy = 1'b1;
      tick();
      bus.rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.si = 1'b0; bus.sh = 1'b0; bus.sync = 1'b0; bus.rdy = 1'b0; bus.clr = 1'b0;
      tick();
      tick();
      chk("rst_q",     32'(bus.q), 32'h0);
      chk("rst_valid", 32'(bus.valid), 32'h0);
      chk("rst_ovr",   32'(bus.ovr), 32'h0);
      chk("rst_perr",  32'(bus.perr), 32'h0);
      chk("rst_busy",  32'(bus.busy), 32'h0);
      rst = 1'b0;

      // 1: bits 1,0,1,1 -> 4'b1101
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      chk("t1_busy_mid",  32'(bus.busy), 32'h1);
      chk("t1_valid_mid", 32'(bus.valid), 32'h0);
      last_bit(1'b1, 4'b1101, 1'b0);
      chk("t1_valid", 32'(bus.valid), 32'h1);
      chk("t1_q",     32'(bus.q), 32'hD);
      chk("t1_busy",  32'(bus.busy), 32'h0);
      consume();
      chk("t1_take", 32'(bus.valid), 32'h0);

      // 2: word A = bits 1,0,0,1 (4'b1001) left pending; 4'b0011 dropped
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      last_bit(1'b1, 4'b1001, 1'b0);
      chk("t2_qa", 32'(bus.q), 32'h9);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      last_bit(1'b0, 4'b0011, 1'b0);
      chk("t2_q_kept", 32'(bus.q), 32'h9);
      chk("t2_valid",  32'(bus.valid), 32'h1);
      chk("t2_ovr",    32'(bus.ovr), 32'h1);
      tick();
      chk("t2_ovr_sticky", 32'(bus.ovr), 32'h1);
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk("t2_ovr_clr", 32'(bus.ovr), 32'h0);
      consume();
      chk("t2_take", 32'(bus.valid), 32'h0);

      // 3: two stray bits, then sync with bit 0 of 0,1,1,0 -> 4'b0110
      send_bit(1'b1); send_bit(1'b1);
      bus.sync = 1'b1;
      send_bit(1'b0);
      bus.sync = 1'b0;
      send_bit(1'b1); send_bit(1'b1);
      chk("t3_no_early", 32'(bus.valid), 32'h0);
      last_bit(1'b0, 4'b0110, 1'b0);
      chk("t3_q",     32'(bus.q), 32'h6);
      chk("t3_valid", 32'(bus.valid), 32'h1);
      chk("t3_ovr",   32'(bus.ovr), 32'h0);

      // 4: 4'b0110 pending, rdy on the completing cycle of 4'b1010
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      last_bit(1'b1, 4'b1010, 1'b1);
      chk("t4_q",     32'(bus.q), 32'hA);
      chk("t4_valid", 32'(bus.valid), 32'h1);
      chk("t4_ovr",   32'(bus.ovr), 32'h0);

      // 5: reset after 3 bits discards them, then 1,1,1,1 -> 4'hF
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_q",     32'(bus.q), 32'h0);
      chk("t5_rst_valid", 32'(bus.valid), 32'h0);
      chk("t5_rst_busy",  32'(bus.busy), 32'h0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      chk("t5_no_early", 32'(bus.valid), 32'h0);
      last_bit(1'b1, 4'b1111, 1'b0);
      chk("t5_q",     32'(bus.q), 32'hF);
      chk("t5_valid", 32'(bus.valid), 32'h1);
      consume();
      chk("t5_take", 32'(bus.valid), 32'h0);

`ifdef PARITY_CHECK_EN
      // 6: data 1,0,0,0 with wrong parity 0, then correct parity 1
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      chk("t6_wait_par", 32'(bus.valid), 32'h0);
      chk("t6_busy_par", 32'(bus.busy), 32'h1);
      send_bit(1'b0);
      chk("t6_q",     32'(bus.q), 32'h1);
      chk("t6_perr1", 32'(bus.perr), 32'h1);
      consume();
      chk("t6_perr_clr", 32'(bus.perr), 32'h0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b1);
      chk("t6_valid", 32'(bus.valid), 32'h1);
      chk("t6_perr0", 32'(bus.perr), 32'h0);
`else
      chk("perr_tied", 32'(bus.perr), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
